// File: rtl/tanh_simd_feeder_if.sv
// Scalar sample stream into the tanh SIMD feeder.
// Ports (signals):
//   s_data  : Q5.11 signed sample
//   s_valid : s_data/s_last valid
//   s_last  : final sample of its packet
//   s_ready : feeder can accept a sample this cycle
// Modports:
//   master : sample source (drives data/valid/last, observes ready)
//   slave  : feeder side (observes data/valid/last, drives ready)
interface tanh_simd_feeder_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/tanh_simd_feeder.sv
// Upstream feeder for the 2-lane tanh pipeline.
// Buffers a scalar Q5.11 sample stream in a small FIFO and issues pairs of
// consecutive samples on x0_out/x1_out with a one-cycle valid_out strobe.
// A packet's last sample is never split from its packet: an odd tail is
// issued alone with lane_mask = 2'b01 and x1_out = 0.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   samples     : slave side of the scalar sample stream
//   x0_out      : lane 0 sample (to pipeline x0_in)
//   x1_out      : lane 1 sample (to pipeline x1_in)
//   valid_out   : pair valid, one cycle per issued pair
//   lane_mask   : 2'b11 full pair, 2'b01 single
//   last_out    : issued pair holds the packet's last sample
//   fifo_count  : current FIFO occupancy
module tanh_simd_feeder #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  tanh_simd_feeder_if.slave             samples,
  output logic [DATA_W-1:0]             x0_out,
  output logic [DATA_W-1:0]             x1_out,
  output logic                          valid_out,
  output logic [1:0]                    lane_mask,
  output logic                          last_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage: one data word and one last flag per entry.
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];

  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  logic [AW-1:0] rd_ptr_next_entry;
  logic          push;
  logic          issue_pair;
  logic          issue_single;
  logic [1:0]    pop_cnt;

  // Ready looks only at the registered count; a same-cycle pop does not
  // free a slot until the following cycle.
  assign samples.s_ready = (count_reg < CW'(FIFO_DEPTH));
  assign push            = samples.s_valid && samples.s_ready;

  // Second entry behind the head; wraps naturally at the pointer width.
  assign rd_ptr_next_entry = rd_ptr_reg + AW'(1);

  // Issue decision from the FIFO state at cycle start. An entry pushed this
  // cycle is not yet counted, so it cannot be issued in the same cycle.
  always_comb begin
    issue_pair   = 1'b0;
    issue_single = 1'b0;
    pop_cnt      = 2'd0;
    if (count_reg != '0) begin
      if (mem_last[rd_ptr_reg]) begin
        issue_single = 1'b1;
        pop_cnt      = 2'd1;
      end else if (count_reg >= CW'(2)) begin
        issue_pair = 1'b1;
        pop_cnt    = 2'd2;
      end
    end
  end

  // Storage writes; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data[wr_ptr_reg] <= samples.s_data;
      mem_last[wr_ptr_reg] <= samples.s_last;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_reg + AW'(pop_cnt);
      count_reg  <= count_reg + CW'(push) - CW'(pop_cnt);
    end
  end

  // Registered issue outputs; lane data and flags hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_out    <= '0;
      x1_out    <= '0;
      valid_out <= 1'b0;
      lane_mask <= 2'b00;
      last_out  <= 1'b0;
    end else begin
      valid_out <= issue_pair || issue_single;
      if (issue_pair) begin
        x0_out    <= mem_data[rd_ptr_reg];
        x1_out    <= mem_data[rd_ptr_next_entry];
        lane_mask <= 2'b11;
        last_out  <= mem_last[rd_ptr_next_entry];
      end else if (issue_single) begin
        x0_out    <= mem_data[rd_ptr_reg];
        x1_out    <= '0;
        lane_mask <= 2'b01;
        last_out  <= 1'b1;
      end
    end
  end

  assign fifo_count = count_reg;

endmodule

// File: tb/tb_tanh_simd_feeder.sv
module tb_tanh_simd_feeder;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 8;

  logic clk;
  logic rst;
  logic [DATA_W-1:0] x0_out;
  logic [DATA_W-1:0] x1_out;
  logic              valid_out;
  logic [1:0]        lane_mask;
  logic              last_out;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  tanh_simd_feeder_if #(.DATA_W(DATA_W)) bus ();

  tanh_simd_feeder #(
    .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .samples(bus.slave),
    .x0_out(x0_out),
    .x1_out(x1_out),
    .valid_out(valid_out),
    .lane_mask(lane_mask),
    .last_out(last_out),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] x1;
    logic [1:0]        mask;
    logic              last;
    int                cyc;
  } issue_t;

  issue_t issue_q[$];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  int     last_acc = 0;
  int     acc2 = 0;

  // Record every issued pair with the edge number it was registered on.
  always @(posedge clk) begin
    issue_t ev;
    cyc = cyc + 1;
    #1;
    if (valid_out === 1'b1) begin
      ev.x0   = x0_out;
      ev.x1   = x1_out;
      ev.mask = lane_mask;
      ev.last = last_out;
      ev.cyc  = cyc;
      issue_q.push_back(ev);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic push(input logic [DATA_W-1:0] d, input logic l);
    int tries;
    @(negedge clk);
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    tries = 0;
    while (bus.s_ready !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    check("push_accept", {31'd0, bus.s_ready}, 32'd1);
    check("ready_vs_count", {31'd0, bus.s_ready}, {31'd0, (fifo_count < FIFO_DEPTH)});
    @(posedge clk);
    #2;
    last_acc = cyc;
    $display("[TB] push data=0x%04h last=%0d at edge %0d", d, l, cyc);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Wait (bounded) for the next issue and compare every field.
  task automatic expect_issue(input string tag, input logic [DATA_W-1:0] ex0,
                              input logic [DATA_W-1:0] ex1, input logic [1:0] emask,
                              input logic elast, input int ecyc);
    issue_t ev;
    int tries;
    tries = 0;
    while (issue_q.size() == 0 && tries < 30) begin
      @(posedge clk);
      #2;
      tries++;
    end
    if (issue_q.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      ev = issue_q.pop_front();
      $display("[TB] %s issue x0=0x%04h x1=0x%04h mask=%b last=%0d at edge %0d",
               tag, ev.x0, ev.x1, ev.mask, ev.last, ev.cyc);
      check({tag, "_x0"}, {16'd0, ev.x0}, {16'd0, ex0});
      check({tag, "_x1"}, {16'd0, ev.x1}, {16'd0, ex1});
      check({tag, "_mask"}, {30'd0, ev.mask}, {30'd0, emask});
      check({tag, "_last"}, {31'd0, ev.last}, {31'd0, elast});
      if (ecyc >= 0) check({tag, "_edge"}, ev.cyc, ecyc);
    end
  endtask

  task automatic expect_none(input string tag);
    repeat (4) @(posedge clk);
    #2;
    check({tag, "_no_extra"}, issue_q.size(), 32'd0);
    issue_q.delete();
  endtask

  initial begin
    bus.s_data  = 16'h1234;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b1;
    rst = 1'b1;

    // Reset held 2 cycles with a sample presented: nothing may enter or issue.
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_count", {28'd0, fifo_count}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    check("rst_x0", {16'd0, x0_out}, 32'd0);
    check("rst_x1", {16'd0, x1_out}, 32'd0);
    check("rst_mask", {30'd0, lane_mask}, 32'd0);
    check("rst_last", {31'd0, last_out}, 32'd0);
    check("rst_ready", {31'd0, bus.s_ready}, 32'd1);
    expect_none("rst");

    // Even stream, back to back; each pair one edge after its 2nd sample.
    push(16'h0800, 1'b0);
    push(16'hF800, 1'b0);
    acc2 = last_acc;
    push(16'h0400, 1'b0);
    push(16'h0000, 1'b1);
    idle();
    expect_issue("even0", 16'h0800, 16'hF800, 2'b11, 1'b0, acc2 + 1);
    expect_issue("even1", 16'h0400, 16'h0000, 2'b11, 1'b1, -1);
    expect_none("even");

    // Odd tail issued alone.
    push(16'h0100, 1'b0);
    push(16'h0200, 1'b0);
    push(16'h0300, 1'b1);
    idle();
    expect_issue("odd0", 16'h0100, 16'h0200, 2'b11, 1'b0, -1);
    expect_issue("odd1", 16'h0300, 16'h0000, 2'b01, 1'b1, -1);
    expect_none("odd");

    // Last on head: never paired across the packet boundary.
    push(16'h1000, 1'b1);
    push(16'h2000, 1'b0);
    push(16'h3000, 1'b1);
    idle();
    expect_issue("head0", 16'h1000, 16'h0000, 2'b01, 1'b1, -1);
    expect_issue("head1", 16'h2000, 16'h3000, 2'b11, 1'b1, -1);
    expect_none("head");

    // Nine non-last samples at full rate, then one lone sample waits.
    for (int i = 1; i <= 9; i++) begin
      push(16'(i * 16'h0010), 1'b0);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      expect_issue("bp", 16'((2 * i + 1) * 16'h0010), 16'((2 * i + 2) * 16'h0010),
                   2'b11, 1'b0, -1);
    end
    repeat (20) begin
      @(posedge clk);
      #1;
      check("wait_valid", {31'd0, valid_out}, 32'd0);
    end
    check("wait_count", {28'd0, fifo_count}, 32'd1);
    issue_q.delete();

    // Mid-operation reset with a push presented during the reset cycle.
    push(16'h0700, 1'b0);
    push(16'h0800, 1'b0);
    push(16'h0900, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.s_data  = 16'h0C00;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("mid_rst_count", {28'd0, fifo_count}, 32'd0);
    check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    issue_q.delete();
    push(16'h0A00, 1'b0);
    push(16'h0B00, 1'b1);
    idle();
    expect_issue("mid", 16'h0A00, 16'h0B00, 2'b11, 1'b1, last_acc + 1);
    expect_none("mid");
    check("final_count", {28'd0, fifo_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
